ram_init_sequencer: RTL

- Parametrised boot-time RAM loader for the accumulator CPU.
- After reset it accepts NUM_WORDS program/data words from a valid/ready source and writes them to RAM addresses 0..NUM_WORDS-1.
- Optionally reads the image back and checks a running checksum, then hands the RAM port to the CPU and raises done.
- Sits between the word source (keypad loader or image ROM), the RAM and the CPU fetch path. The RAM clock select stays in the top level, keyed on done.

---
 rtl/cpu_defs.sv | 17 +
 rtl/checksum_acc.sv | 28 ++
 rtl/ram_init_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the accumulator CPU: global word/address size
// and the boot sequencer state encoding.
// Pure declarations; no timing or flow control.
package cpu_defs;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/checksum_acc.sv
// Modular (2**DATA_W) running sum with synchronous clear and enable.
// Latency: sum reflects data one cycle after enable.
// No backpressure: accepts data on every enabled cycle; clear wins over enable.
// Ports: init_clock/init_reset, clear, enable, data in, sum out.
module checksum_acc
    import cpu_defs::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              init_clock,
    input  logic              init_reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge init_clock or posedge init_reset) begin
        if (init_reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (enable) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/ram_init_sequencer.sv
// Boot-time RAM loader: streams NUM_WORDS words into RAM, optionally re-reads and checksums them, then hands RAM to the CPU.
// Latency: write is combinational in the handshake cycle; verify pass takes NUM_WORDS+RD_LAT cycles.
// Backpressure: src_ready high only in LOAD; a stalled source (src_valid=0) freezes the load.
// Ports: start/src_* (word source), cpu_* (CPU path, muxed in DONE), ram_* (RAM port),
//        busy/done/error status, checksum (load-side sum, held after load).
module ram_init_sequencer
    import cpu_defs::*;
#(
    parameter int DATA_W     = CPU_DATA_W,
    parameter int ADDR_W     = CPU_ADDR_W,
    parameter int NUM_WORDS  = 5,
    parameter int VERIFY_EN  = 1,
    parameter int RD_LAT     = 1,
    parameter int AUTO_START = 1
) (
    input  logic              init_clock,
    input  logic              init_reset,
    input  logic              start,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);

    // One spare bit so NUM_WORDS = 2**ADDR_W reaches its terminal value without wrapping.
    localparam int CNT_W = ADDR_W + 1;
    localparam int VC_W  = $clog2(NUM_WORDS + RD_LAT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_WORDS - 1);
    localparam logic [VC_W-1:0]  VC_ISSUES = VC_W'(NUM_WORDS);
    localparam logic [VC_W-1:0]  VC_LAST   = VC_W'(NUM_WORDS + RD_LAT - 1);
    localparam seq_state_t       RESET_ST  = (AUTO_START != 0) ? ST_LOAD : ST_IDLE;

    seq_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [VC_W-1:0]   vcnt, vcnt_nxt;
    logic              issue;
    logic              ret_tag;
    logic              clr_sums;
    logic              ld_en;
    logic [DATA_W-1:0] vsum;
    logic [DATA_W-1:0] vsum_final;

    always_ff @(posedge init_clock or posedge init_reset) begin
        if (init_reset) begin
            state <= RESET_ST;
            cnt   <= '0;
            vcnt  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            vcnt  <= vcnt_nxt;
        end
    end

    // Read issue window: first NUM_WORDS cycles of VERIFY.
    assign issue = (state == ST_VERIFY) && (vcnt < VC_ISSUES);

    // Tag pipeline matching RAM read latency; ret_tag marks a cycle whose ram_rdata belongs to the image.
    generate
        if (RD_LAT == 0) begin : g_tag_comb
            assign ret_tag = issue;
        end else begin : g_tag_pipe
            logic [RD_LAT-1:0] tag_pipe;
            always_ff @(posedge init_clock or posedge init_reset) begin
                if (init_reset) begin
                    tag_pipe <= '0;
                end else begin
                    tag_pipe[0] <= issue;
                    for (int i = 1; i < RD_LAT; i++) begin
                        tag_pipe[i] <= tag_pipe[i-1];
                    end
                end
            end
            assign ret_tag = tag_pipe[RD_LAT-1];
        end
    endgenerate

    // The final return lands in the same cycle as the compare, so fold it in ahead of the register.
    assign vsum_final = vsum + (ret_tag ? ram_rdata : '0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vcnt_nxt  = vcnt;
        clr_sums  = 1'b0;
        ld_en     = 1'b0;
        src_ready = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        // The reset state may be LOAD; keep every output quiet while reset is still asserted.
        if (!init_reset) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_LOAD;
                        cnt_nxt   = '0;
                        clr_sums  = 1'b1;
                    end
                end
                ST_LOAD: begin
                    busy      = 1'b1;
                    src_ready = 1'b1;
                    ram_addr  = cnt[ADDR_W-1:0];
                    if (src_valid) begin
                        ram_we    = 1'b1;
                        ram_wdata = src_data;
                        ld_en     = 1'b1;
                        cnt_nxt   = cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            vcnt_nxt  = '0;
                            state_nxt = (VERIFY_EN != 0) ? ST_VERIFY : ST_DONE;
                        end
                    end
                end
                ST_VERIFY: begin
                    busy     = 1'b1;
                    vcnt_nxt = vcnt + VC_W'(1);
                    if (issue) begin
                        ram_addr = ADDR_W'(vcnt);
                    end
                    if (vcnt == VC_LAST) begin
                        state_nxt = (vsum_final == checksum) ? ST_DONE : ST_ERROR;
                    end
                end
                ST_DONE: begin
                    done      = 1'b1;
                    ram_addr  = cpu_addr;
                    ram_we    = cpu_we;
                    ram_wdata = cpu_wdata;
                    if (start) begin
                        state_nxt = ST_LOAD;
                        cnt_nxt   = '0;
                        clr_sums  = 1'b1;
                    end
                end
                ST_ERROR: begin
                    error = 1'b1;
                    if (start) begin
                        state_nxt = ST_LOAD;
                        cnt_nxt   = '0;
                        clr_sums  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    checksum_acc #(.DATA_W(DATA_W)) u_load_acc (
        .init_clock (init_clock),
        .init_reset (init_reset),
        .clear      (clr_sums),
        .enable     (ld_en),
        .data       (src_data),
        .sum        (checksum)
    );

    checksum_acc #(.DATA_W(DATA_W)) u_verify_acc (
        .init_clock (init_clock),
        .init_reset (init_reset),
        .clear      (clr_sums),
        .enable     (ret_tag),
        .data       (ram_rdata),
        .sum        (vsum)
    );

endmodule
